fetch_unit: RTL and testbench

//  Instruction-fetch stage that sits directly downstream of the PC register.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_timeout_ctr.sv | 22 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, the fault instruction,
// and the fetch-stage state encoding.
package cpu_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Cycle counter for an outstanding fetch; expired is high in the cycle
// where the count reaches TIMEOUT-1.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + W'(1);
  end

  assign expired = (count == W'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem request per PC, holds the IF/ID
// payload under stall, and drops in-flight fetches on a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
  parameter int                 TIMEOUT   = 64
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc_incr,
  output logic              pc_we,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_incr,
  output logic              if_fault,
  output logic [1:0]        dbg_state
);
  // Handshake: a request transfers on the cycle where imem_req_valid and
  // imem_req_ready are both high; valid never depends on ready. Responses are
  // single-cycle pulses with no backpressure and arrive in request order.
  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic              drop_pend;
  logic              misaligned, handshake, expired;
  logic              resp_take, timeout_fault;

  assign misaligned = (pc_in[1:0] != 2'b00);
  assign handshake  = imem_req_valid && imem_req_ready;
  // drop_pend marks a response still owed for a fetch that already timed out
  assign resp_take     = (state == WAIT) && !flush && imem_resp_valid && !drop_pend;
  assign timeout_fault = (state == WAIT) && !flush && expired &&
                         !(imem_resp_valid && !drop_pend);

  fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .rst     (rst),
    .clear   (state != WAIT),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (rst) state <= REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      REQ: begin
        if (flush)           state_next = handshake ? DROP : REQ;
        else if (misaligned) state_next = HOLD;
        else if (handshake)  state_next = WAIT;
      end
      WAIT: begin
        if (flush)              state_next = (imem_resp_valid && !drop_pend) ? REQ : DROP;
        else if (resp_take)     state_next = HOLD;
        else if (timeout_fault) state_next = HOLD;
      end
      HOLD: begin
        if (flush || !stall) state_next = REQ;
      end
      DROP: begin
        if (imem_resp_valid && !drop_pend) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = !rst && (state == REQ) && !misaligned;
    imem_req_addr  = pc_in;
    pc_we          = !rst && (flush || ((state == HOLD) && !stall));
    pc_incr        = pc_in + ADDR_W'(4);
    dbg_state      = state;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      fetch_pc  <= '0;
      drop_pend <= 1'b0;
    end else begin
      if (handshake) fetch_pc <= pc_in;
      if (timeout_fault)        drop_pend <= 1'b1;
      else if (imem_resp_valid) drop_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      if_valid   <= 1'b0;
      if_fault   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_incr <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
      if_fault <= 1'b0;
    end else if ((state == REQ) && misaligned) begin
      if_valid   <= 1'b1;
      if_fault   <= 1'b1;
      if_instr   <= NOP_INSTR;
      if_pc      <= pc_in;
      if_pc_incr <= pc_in + ADDR_W'(4);
    end else if (resp_take) begin
      if_valid   <= 1'b1;
      if_fault   <= 1'b0;
      if_instr   <= imem_resp_data;
      if_pc      <= fetch_pc;
      if_pc_incr <= fetch_pc + ADDR_W'(4);
    end else if (timeout_fault) begin
      if_valid   <= 1'b1;
      if_fault   <= 1'b1;
      if_instr   <= NOP_INSTR;
      if_pc      <= fetch_pc;
      if_pc_incr <= fetch_pc + ADDR_W'(4);
    end else if ((state == HOLD) && !stall) begin
      if_valid <= 1'b0;
      if_fault <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: normal fetch, stall hold, flush drop,
// misaligned fault, timeout fault, PC wrap and flush/stall priority.
module tb_fetch_unit;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush, stall;
  logic [31:0] pc_incr;
  logic        pc_we;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_fault;
  logic [31:0] if_instr, if_pc, if_pc_incr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(32'h0000_0000), .TIMEOUT(TO)) dut (
    .clock           (clock),
    .rst             (rst),
    .pc_in           (pc_in),
    .flush           (flush),
    .stall           (stall),
    .pc_incr         (pc_incr),
    .pc_we           (pc_we),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_incr      (if_pc_incr),
    .if_fault        (if_fault),
    .dbg_state       (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_in = 32'h0; flush = 1'b0; stall = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    tick(); tick();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_fault", 32'(if_fault), 32'd0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // 1: basic fetch, memory answers 2 cycles after acceptance
    rst = 1'b0; #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    chk("t1_pc_we_req", 32'(pc_we), 32'd0);
    tick();
    imem_req_ready = 1'b0; #1;
    chk("t1_wait_state", 32'(dbg_state), 32'd1);
    chk("t1_wait_reqv", 32'(imem_req_valid), 32'd0);
    chk("t1_wait_ifv", 32'(if_valid), 32'd0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h8C01_0004;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t1_if_valid", 32'(if_valid), 32'd1);
    chk("t1_if_instr", if_instr, 32'h8C01_0004);
    chk("t1_if_pc", if_pc, 32'h0);
    chk("t1_if_pc_incr", if_pc_incr, 32'h4);
    chk("t1_pc_we", 32'(pc_we), 32'd1);
    tick();
    chk("t1_pc_we_off", 32'(pc_we), 32'd0);
    chk("t1_ifv_off", 32'(if_valid), 32'd0);

    // 2: stall holds the payload for 3 cycles
    pc_in = 32'h4; imem_req_ready = 1'b1; #1;
    chk("t2_req_addr", imem_req_addr, 32'h4);
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0043_0820;
    tick();
    imem_resp_valid = 1'b0; stall = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_instr", if_instr, 32'h0043_0820);
      chk("t2_hold_pc", if_pc, 32'h4);
      chk("t2_hold_valid", 32'(if_valid), 32'd1);
      chk("t2_hold_pc_we", 32'(pc_we), 32'd0);
      if (i < 2) tick();
    end
    stall = 1'b0; #1;
    chk("t2_release_pc_we", 32'(pc_we), 32'd1);
    chk("t2_pc_incr_reg", if_pc_incr, 32'h8);
    tick();
    chk("t2_after_pc_we", 32'(pc_we), 32'd0);
    chk("t2_after_ifv", 32'(if_valid), 32'd0);

    // 3: flush during WAIT, late response discarded
    pc_in = 32'h8; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1; pc_in = 32'h40; #1;
    chk("t3_flush_pc_we", 32'(pc_we), 32'd1);
    tick();
    flush = 1'b0; #1;
    chk("t3_drop_state", 32'(dbg_state), 32'd3);
    chk("t3_drop_ifv", 32'(if_valid), 32'd0);
    chk("t3_drop_reqv", 32'(imem_req_valid), 32'd0);
    chk("t3_drop_pc_we", 32'(pc_we), 32'd0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0; imem_req_ready = 1'b1; #1;
    chk("t3_req_state", 32'(dbg_state), 32'd0);
    chk("t3_discard_ifv", 32'(if_valid), 32'd0);
    chk("t3_new_reqv", 32'(imem_req_valid), 32'd1);
    chk("t3_new_addr", imem_req_addr, 32'h40);
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_2222;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t3_instr", if_instr, 32'h1111_2222);
    chk("t3_if_pc", if_pc, 32'h40);
    chk("t3_if_pc_incr", if_pc_incr, 32'h44);
    tick();

    // 4: misaligned PC faults without a request
    pc_in = 32'h6; #1;
    chk("t4_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    chk("t4_fault", 32'(if_fault), 32'd1);
    chk("t4_valid", 32'(if_valid), 32'd1);
    chk("t4_nop", if_instr, 32'h0);
    chk("t4_if_pc", if_pc, 32'h6);
    chk("t4_if_pc_incr", if_pc_incr, 32'hA);
    tick();
    chk("t4_fault_clr", 32'(if_fault), 32'd0);

    // 5: silent memory times out, late response dropped
    pc_in = 32'h80; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; #1;
    for (int i = 0; i < TO; i++) begin
      chk("t5_wait_state", 32'(dbg_state), 32'd1);
      chk("t5_no_fault", 32'(if_fault), 32'd0);
      tick();
    end
    chk("t5_fault", 32'(if_fault), 32'd1);
    chk("t5_valid", 32'(if_valid), 32'd1);
    chk("t5_nop", if_instr, 32'h0);
    chk("t5_if_pc", if_pc, 32'h80);
    chk("t5_hold", 32'(dbg_state), 32'd2);
    pc_in = 32'h84;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBADB_AD00;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t5_late_ifv", 32'(if_valid), 32'd0);
    chk("t5_late_instr", if_instr, 32'h0);
    chk("t5_late_state", 32'(dbg_state), 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_3333;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t5_next_instr", if_instr, 32'h2222_3333);
    chk("t5_next_pc", if_pc, 32'h84);
    chk("t5_next_fault", 32'(if_fault), 32'd0);
    tick();

    // 6: PC wrap, then flush beats stall
    pc_in = 32'hFFFF_FFFC; #1;
    chk("t6_pc_incr_wrap", pc_incr, 32'h0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_4444;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t6_if_pc_incr_wrap", if_pc_incr, 32'h0);
    chk("t6_instr", if_instr, 32'h3333_4444);
    stall = 1'b1; flush = 1'b1; #1;
    chk("t6_flush_pc_we", 32'(pc_we), 32'd1);
    tick();
    chk("t6_flush_ifv", 32'(if_valid), 32'd0);
    chk("t6_flush_state", 32'(dbg_state), 32'd0);
    chk("t6_flush2_pc_we", 32'(pc_we), 32'd1);
    flush = 1'b0; stall = 1'b0; #1;
    chk("t6_pc_we_off", 32'(pc_we), 32'd0);

    // flush together with the request handshake drops the request
    pc_in = 32'h0; imem_req_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; imem_req_ready = 1'b0; #1;
    chk("t7_hs_flush_drop", 32'(dbg_state), 32'd3);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_6666;
    tick();
    imem_resp_valid = 1'b0; #1;
    chk("t7_back_req", 32'(dbg_state), 32'd0);
    chk("t7_ifv", 32'(if_valid), 32'd0);

    // reset in the middle of WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("t8_rst_state", 32'(dbg_state), 32'd0);
    chk("t8_rst_ifv", 32'(if_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
